// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl -- multi-cycle control FSM for the MIPS core.
//
// Sequences the shared ALU, the immediate extender, PC, IR, register file and
// data memory through fetch / decode / execute / memory / writeback. Data
// memory accesses hold in MRD/MWR until dmem_ready. A retired-instruction
// counter (instret) counts every completed instruction and wraps.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   opcode, funct     IR[31:26] / IR[5:0]
//   alu_zero          ALU result == 0 (used for beq)
//   dmem_ready        data memory completes its access this cycle
//   pc_wr, npc_sel    PC load enable / next-PC source
//   ir_wr             IR load enable
//   reg_wr, reg_dst   register-file write enable / destination (0 rt, 1 rd)
//   mem_to_reg        write-back source (0 ALU, 1 memory)
//   alu_src_b, alu_op ALU operand-B source / operation
//   ext_sign          extender mode (1 sign, 0 zero)
//   dm_rd, dm_wr      data-memory read / write request
//   illegal, retired  one-cycle pulses
//   instret           retired-instruction count
//   state_o           current state encoding (debug)
// ---------------------------------------------------------------------------
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             dmem_ready,
    output logic             pc_wr,
    output logic [1:0]       npc_sel,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_b,
    output logic             ext_sign,
    output logic [2:0]       alu_op,
    output logic             dm_rd,
    output logic             dm_wr,
    output logic             illegal,
    output logic             retired,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_INIT  = 4'd0,
        S_FETCH = 4'd1,
        S_DCD   = 4'd2,
        S_EXE   = 4'd3,
        S_WB    = 4'd4,
        S_ADR   = 4'd5,
        S_MRD   = 4'd6,
        S_MWB   = 4'd7,
        S_MWR   = 4'd8,
        S_BR    = 4'd9,
        S_JMP   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    // Instruction decode
    logic is_addu, is_subu, is_rtype, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
    logic is_legal;

    always_comb begin
        is_addu  = (opcode == OP_RTYPE) && (funct == FN_ADDU);
        is_subu  = (opcode == OP_RTYPE) && (funct == FN_SUBU);
        is_rtype = is_addu || is_subu;
        is_ori   = (opcode == OP_ORI);
        is_lui   = (opcode == OP_LUI);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_beq   = (opcode == OP_BEQ);
        is_j     = (opcode == OP_J);
        is_legal = is_rtype || is_ori || is_lui || is_lw || is_sw || is_beq || is_j;
    end

    // Next state and Moore-per-state outputs
    always_comb begin
        state_d    = state_q;
        pc_wr      = 1'b0;
        npc_sel    = 2'b00;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        dm_rd      = 1'b0;
        dm_wr      = 1'b0;
        illegal    = 1'b0;
        retired    = 1'b0;
        // Immediates of loads, stores and branch offsets are signed; the
        // logical immediates (ori/lui) are zero-extended.
        ext_sign   = (state_q != S_INIT) && (is_lw || is_sw || is_beq);

        unique case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_wr   = 1'b1;
                pc_wr   = 1'b1;
                state_d = S_DCD;
            end
            S_DCD: begin
                if (is_rtype || is_ori || is_lui) begin
                    state_d = S_EXE;
                end else if (is_lw || is_sw) begin
                    state_d = S_ADR;
                end else if (is_beq) begin
                    state_d = S_BR;
                end else if (is_j) begin
                    state_d = S_JMP;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXE: begin
                if (is_ori) begin
                    alu_src_b = 1'b1;
                    alu_op    = ALU_OR;
                end else if (is_lui) begin
                    alu_src_b = 1'b1;
                    alu_op    = ALU_LUI;
                end else begin
                    alu_op    = is_subu ? ALU_SUB : ALU_ADD;
                end
                state_d = S_WB;
            end
            S_WB: begin
                reg_wr  = 1'b1;
                reg_dst = is_rtype;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_ADR: begin
                alu_src_b = 1'b1;
                state_d   = is_sw ? S_MWR : S_MRD;
            end
            S_MRD: begin
                dm_rd     = 1'b1;
                alu_src_b = 1'b1;
                if (dmem_ready) begin
                    state_d = S_MWB;
                end
            end
            S_MWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                retired    = 1'b1;
                state_d    = S_FETCH;
            end
            S_MWR: begin
                dm_wr     = 1'b1;
                alu_src_b = 1'b1;
                // The store completes (and retires) on the ready cycle itself.
                if (dmem_ready) begin
                    retired = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BR: begin
                alu_op  = ALU_SUB;
                pc_wr   = alu_zero;
                npc_sel = 2'b01;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_JMP: begin
                pc_wr   = 1'b1;
                npc_sel = 2'b10;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                // Unreachable encodings recover to FETCH.
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        instret_d = instret_q + (retired ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
//
// A table of per-cycle {inputs, expected outputs} records walks a sequence of
// instructions; hand-written sequences cover reset during a stalled store and
// counter wrap on a CNT_W=4 instance that shares all inputs.
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100001;
    localparam logic [5:0] FN_SUB = 6'b100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        alu_zero, dmem_ready;

    logic        pc_wr, ir_wr, reg_wr, reg_dst, mem_to_reg, alu_src_b, ext_sign;
    logic        dm_rd, dm_wr, illegal, retired;
    logic [1:0]  npc_sel;
    logic [2:0]  alu_op;
    logic [31:0] instret;
    logic [3:0]  state_o;

    logic        pc_wr_4, ir_wr_4, reg_wr_4, reg_dst_4, mem_to_reg_4, alu_src_b_4, ext_sign_4;
    logic        dm_rd_4, dm_wr_4, illegal_4, retired_4;
    logic [1:0]  npc_sel_4;
    logic [2:0]  alu_op_4;
    logic [3:0]  instret_4;
    logic [3:0]  state_o_4;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .dmem_ready(dmem_ready),
        .pc_wr(pc_wr), .npc_sel(npc_sel), .ir_wr(ir_wr), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
        .ext_sign(ext_sign), .alu_op(alu_op), .dm_rd(dm_rd), .dm_wr(dm_wr),
        .illegal(illegal), .retired(retired), .instret(instret), .state_o(state_o)
    );

    mc_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .dmem_ready(dmem_ready),
        .pc_wr(pc_wr_4), .npc_sel(npc_sel_4), .ir_wr(ir_wr_4), .reg_wr(reg_wr_4),
        .reg_dst(reg_dst_4), .mem_to_reg(mem_to_reg_4), .alu_src_b(alu_src_b_4),
        .ext_sign(ext_sign_4), .alu_op(alu_op_4), .dm_rd(dm_rd_4), .dm_wr(dm_wr_4),
        .illegal(illegal_4), .retired(retired_4), .instret(instret_4), .state_o(state_o_4)
    );

    // Packed output vector:
    // {state(4), pc_wr, npc_sel(2), ir_wr, reg_wr, reg_dst, mem_to_reg,
    //  alu_src_b, ext_sign, alu_op(3), dm_rd, dm_wr, illegal, retired}
    logic [19:0] act, act4;
    assign act  = {state_o, pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, mem_to_reg,
                   alu_src_b, ext_sign, alu_op, dm_rd, dm_wr, illegal, retired};
    assign act4 = {state_o_4, pc_wr_4, npc_sel_4, ir_wr_4, reg_wr_4, reg_dst_4, mem_to_reg_4,
                   alu_src_b_4, ext_sign_4, alu_op_4, dm_rd_4, dm_wr_4, illegal_4, retired_4};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic void mk(
        input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy,
        input logic [3:0] st, input logic pcw, input logic [1:0] npc, input logic irw,
        input logic rw, input logic rdst, input logic m2r, input logic asb, input logic es,
        input logic [2:0] aop, input logic drd, input logic dwr, input logic ill,
        input logic ret);
        vec_t v;
        v.op  = op;
        v.fn  = fn;
        v.z   = z;
        v.rdy = rdy;
        v.exp = {st, pcw, npc, irw, rw, rdst, m2r, asb, es, aop, drd, dwr, ill, ret};
        vecs.push_back(v);
    endfunction

    int unsigned exp_cnt;

    initial begin
        rst_n      = 1'b0;
        opcode     = OP_ORI;
        funct      = 6'd0;
        alu_zero   = 1'b0;
        dmem_ready = 1'b1;

        //    op      fn      z  rdy st  pcw npc   irw rw rd m2r asb es aop     drd dwr ill ret
        // ori
        mk(OP_ORI, 6'd0,  0, 1, 0,  0, 2'b00, 0,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_ORI, 6'd0,  0, 1, 1,  1, 2'b00, 1,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_ORI, 6'd0,  0, 1, 2,  0, 2'b00, 0,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_ORI, 6'd0,  0, 1, 3,  0, 2'b00, 0,  0, 0, 0,  1,  0, 3'b010, 0,  0,  0,  0);
        mk(OP_ORI, 6'd0,  0, 1, 4,  0, 2'b00, 0,  1, 0, 0,  0,  0, 3'b000, 0,  0,  0,  1);
        // lw with two wait states
        mk(OP_LW,  6'd0,  0, 1, 1,  1, 2'b00, 1,  0, 0, 0,  0,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_LW,  6'd0,  0, 1, 2,  0, 2'b00, 0,  0, 0, 0,  0,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_LW,  6'd0,  0, 1, 5,  0, 2'b00, 0,  0, 0, 0,  1,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_LW,  6'd0,  0, 0, 6,  0, 2'b00, 0,  0, 0, 0,  1,  1, 3'b000, 1,  0,  0,  0);
        mk(OP_LW,  6'd0,  0, 0, 6,  0, 2'b00, 0,  0, 0, 0,  1,  1, 3'b000, 1,  0,  0,  0);
        mk(OP_LW,  6'd0,  0, 1, 6,  0, 2'b00, 0,  0, 0, 0,  1,  1, 3'b000, 1,  0,  0,  0);
        mk(OP_LW,  6'd0,  0, 1, 7,  0, 2'b00, 0,  1, 0, 1,  0,  1, 3'b000, 0,  0,  0,  1);
        // sw, no wait
        mk(OP_SW,  6'd0,  0, 1, 1,  1, 2'b00, 1,  0, 0, 0,  0,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_SW,  6'd0,  0, 1, 2,  0, 2'b00, 0,  0, 0, 0,  0,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_SW,  6'd0,  0, 1, 5,  0, 2'b00, 0,  0, 0, 0,  1,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_SW,  6'd0,  0, 1, 8,  0, 2'b00, 0,  0, 0, 0,  1,  1, 3'b000, 0,  1,  0,  1);
        // sw, one wait
        mk(OP_SW,  6'd0,  0, 1, 1,  1, 2'b00, 1,  0, 0, 0,  0,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_SW,  6'd0,  0, 1, 2,  0, 2'b00, 0,  0, 0, 0,  0,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_SW,  6'd0,  0, 1, 5,  0, 2'b00, 0,  0, 0, 0,  1,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_SW,  6'd0,  0, 0, 8,  0, 2'b00, 0,  0, 0, 0,  1,  1, 3'b000, 0,  1,  0,  0);
        mk(OP_SW,  6'd0,  0, 1, 8,  0, 2'b00, 0,  0, 0, 0,  1,  1, 3'b000, 0,  1,  0,  1);
        // beq taken
        mk(OP_BEQ, 6'd0,  1, 1, 1,  1, 2'b00, 1,  0, 0, 0,  0,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_BEQ, 6'd0,  1, 1, 2,  0, 2'b00, 0,  0, 0, 0,  0,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_BEQ, 6'd0,  1, 1, 9,  1, 2'b01, 0,  0, 0, 0,  0,  1, 3'b001, 0,  0,  0,  1);
        // beq not taken
        mk(OP_BEQ, 6'd0,  0, 1, 1,  1, 2'b00, 1,  0, 0, 0,  0,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_BEQ, 6'd0,  0, 1, 2,  0, 2'b00, 0,  0, 0, 0,  0,  1, 3'b000, 0,  0,  0,  0);
        mk(OP_BEQ, 6'd0,  0, 1, 9,  0, 2'b01, 0,  0, 0, 0,  0,  1, 3'b001, 0,  0,  0,  1);
        // addu
        mk(OP_R,   FN_ADD, 1, 0, 1, 1, 2'b00, 1,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_R,   FN_ADD, 1, 0, 2, 0, 2'b00, 0,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_R,   FN_ADD, 1, 0, 3, 0, 2'b00, 0,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_R,   FN_ADD, 1, 0, 4, 0, 2'b00, 0,  1, 1, 0,  0,  0, 3'b000, 0,  0,  0,  1);
        // subu
        mk(OP_R,   FN_SUB, 0, 1, 1, 1, 2'b00, 1,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_R,   FN_SUB, 0, 1, 2, 0, 2'b00, 0,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_R,   FN_SUB, 0, 1, 3, 0, 2'b00, 0,  0, 0, 0,  0,  0, 3'b001, 0,  0,  0,  0);
        mk(OP_R,   FN_SUB, 0, 1, 4, 0, 2'b00, 0,  1, 1, 0,  0,  0, 3'b000, 0,  0,  0,  1);
        // lui
        mk(OP_LUI, 6'd0,  0, 1, 1,  1, 2'b00, 1,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_LUI, 6'd0,  0, 1, 2,  0, 2'b00, 0,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_LUI, 6'd0,  0, 1, 3,  0, 2'b00, 0,  0, 0, 0,  1,  0, 3'b011, 0,  0,  0,  0);
        mk(OP_LUI, 6'd0,  0, 1, 4,  0, 2'b00, 0,  1, 0, 0,  0,  0, 3'b000, 0,  0,  0,  1);
        // illegal: R-type with unknown funct, then opcode 111111
        mk(OP_R,   6'd0,  0, 1, 1,  1, 2'b00, 1,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_R,   6'd0,  0, 1, 2,  0, 2'b00, 0,  0, 0, 0,  0,  0, 3'b000, 0,  0,  1,  0);
        mk(OP_BAD, 6'd0,  0, 1, 1,  1, 2'b00, 1,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_BAD, 6'd0,  0, 1, 2,  0, 2'b00, 0,  0, 0, 0,  0,  0, 3'b000, 0,  0,  1,  0);
        // j
        mk(OP_J,   6'd0,  0, 1, 1,  1, 2'b00, 1,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_J,   6'd0,  0, 1, 2,  0, 2'b00, 0,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  0);
        mk(OP_J,   6'd0,  0, 1, 10, 1, 2'b10, 0,  0, 0, 0,  0,  0, 3'b000, 0,  0,  0,  1);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 64'(act), 64'd0);
        check("reset_instret", 64'(instret), 64'd0);

        // Table walk; release reset just before the first (INIT) vector
        rst_n   = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            opcode     = vecs[i].op;
            funct      = vecs[i].fn;
            alu_zero   = vecs[i].z;
            dmem_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_outputs", i), 64'(act), 64'(vecs[i].exp));
            check($sformatf("vec%0d_outputs_w4", i), 64'(act4), 64'(vecs[i].exp));
            check($sformatf("vec%0d_instret", i), 64'(instret), 64'(exp_cnt));
            check($sformatf("vec%0d_instret_w4", i), 64'(instret_4), 64'(exp_cnt % 16));
            $display("vec %0d: op=%b fn=%b state=%0d instret=%0d", i, vecs[i].op,
                     vecs[i].fn, state_o, instret);
            if (vecs[i].exp[0]) exp_cnt++;
            @(negedge clk);
        end

        // Reset asserted during a stalled store
        opcode     = OP_SW;
        funct      = 6'd0;
        dmem_ready = 1'b0;
        #1;
        check("rst_seq_fetch", 64'(state_o), 64'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_seq_mwr_state", 64'(state_o), 64'd8);
        check("rst_seq_mwr_dm_wr", 64'(dm_wr), 64'd1);
        check("rst_seq_instret_before", 64'(instret), 64'(exp_cnt));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_seq_dm_wr_drop", 64'(dm_wr), 64'd0);
        check("rst_seq_outputs_zero", 64'(act), 64'd0);
        check("rst_seq_instret_zero", 64'(instret), 64'd0);
        check("rst_seq_instret_zero_w4", 64'(instret_4), 64'd0);
        $display("reset during MWR: state=%0d dm_wr=%b instret=%0d", state_o, dm_wr, instret);
        @(negedge clk);
        rst_n      = 1'b1;
        opcode     = OP_J;
        dmem_ready = 1'b1;
        #1;
        check("rst_seq_release_init", 64'(state_o), 64'd0);
        @(negedge clk);
        #1;
        check("rst_seq_release_fetch", 64'(state_o), 64'd1);
        check("rst_seq_no_retire", 64'(instret), 64'd0);

        // Counter wrap on the 4-bit instance: 15 jumps then a 16th
        repeat (45) @(posedge clk);
        #1;
        check("wrap_pre_state", 64'(state_o), 64'd1);
        check("wrap_pre_instret_w4", 64'(instret_4), 64'd15);
        check("wrap_pre_instret", 64'(instret), 64'd15);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("wrap_jmp_outputs", 64'(act),
              64'({4'd10, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000,
                   1'b0, 1'b0, 1'b0, 1'b1}));
        @(posedge clk);
        #1;
        check("wrap_instret_w4", 64'(instret_4), 64'd0);
        check("wrap_instret", 64'(instret), 64'd16);
        check("wrap_back_to_fetch", 64'(state_o), 64'd1);
        $display("wrap: instret_w4=%0d instret=%0d", instret_4, instret);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
